// File: rtl/config_arb_pkg.sv
// Shared types and message-layout helpers for the configuration-port arbiter.
// Messages are packed {addr, flag, payload}, payload in the low bits.
package config_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_ADDR_SIZE    = 4;
    localparam int unsigned DEF_PAYLOAD_SIZE = 8;
    localparam int unsigned DEF_TIMEOUT      = 16;
    localparam int unsigned PAYLOAD_LSB      = 0;

    function automatic int unsigned msg_width(input int unsigned addr_size,
                                              input int unsigned payload_size);
        return addr_size + payload_size + 1;
    endfunction

    function automatic int unsigned flag_idx(input int unsigned payload_size);
        return payload_size;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned payload_size);
        return payload_size + 1;
    endfunction

    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/config_arb_rr_arbiter.sv
// Round-robin selector: first asserted request at or above ptr, wrapping.
// Pure combinational; the owner of ptr decides when it advances.
module rr_arbiter
    import config_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = ID_W'((32'(ptr) + off) % NUM_REQ);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/config_arb.sv
// Arbitrates NUM_REQ requesters onto one configuration-register port,
// one transaction in flight, with a response timeout.
module config_arb
    import config_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter  int unsigned ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter  int unsigned PAYLOAD_SIZE = DEF_PAYLOAD_SIZE,
    parameter  int unsigned TIMEOUT      = DEF_TIMEOUT,
    localparam int unsigned MSG_W        = msg_width(ADDR_SIZE, PAYLOAD_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_val,
    output logic [NUM_REQ-1:0]       req_rdy,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    output logic [NUM_REQ-1:0]       resp_val,
    input  logic [NUM_REQ-1:0]       resp_rdy,
    output logic [MSG_W-1:0]         resp_msg,
    output logic                     cfg_send_val,
    input  logic                     cfg_send_rdy,
    output logic [MSG_W-1:0]         cfg_send_msg,
    input  logic                     cfg_recv_val,
    output logic                     cfg_recv_rdy,
    input  logic [MSG_W-1:0]         cfg_recv_msg,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned ID_W     = id_width(NUM_REQ);
    localparam int unsigned TMR_W    = $clog2(TIMEOUT) + 1;
    localparam int unsigned ADDR_LSB = addr_lsb(PAYLOAD_SIZE);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [MSG_W-1:0]   resp_q, resp_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req      (req_val),
        .ptr      (rr_ptr_q),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    // Outputs decode the registered state but are forced low while reset is
    // held, so a transaction interrupted by reset never leaks a handshake.
    always_comb begin
        req_rdy      = (state_q == IDLE && !reset) ? arb_grant : '0;
        cfg_send_val = (state_q == ISSUE) && !reset;
        cfg_recv_rdy = (state_q == WAIT) && !reset;
        busy         = (state_q != IDLE) && !reset;
        timeout_err  = timeout_err_q && !reset;
        cfg_send_msg = msg_q;
        resp_msg     = resp_q;
        resp_val     = '0;
        if (state_q == RESP && !reset) begin
            resp_val[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        msg_d         = msg_q;
        resp_d        = resp_q;
        timer_d       = timer_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    msg_d   = req_msg[32'(arb_id)*MSG_W +: MSG_W];
                    owner_d = arb_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cfg_send_rdy) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the expiry cycle wins over the timeout.
                if (cfg_recv_val) begin
                    resp_d  = cfg_recv_msg;
                    state_d = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    resp_d                     = '0;
                    resp_d[MSG_W-1:ADDR_LSB]   = msg_q[MSG_W-1:ADDR_LSB];
                    timeout_err_d              = 1'b1;
                    state_d                    = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_rdy[owner_q]) begin
                    rr_ptr_d = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            msg_q         <= '0;
            resp_q        <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            msg_q         <= msg_d;
            resp_q        <= resp_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_config_arb.sv
// Directed bench for config_arb: the bench plays the configuration register
// and the requesters, and scoreboards expected responses per transaction.
module tb_config_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = 8;
    localparam int unsigned TO = 16;
    localparam int unsigned MW = AW + PW + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_val;
    logic [N-1:0]    req_rdy;
    logic [N*MW-1:0] req_msg;
    logic [N-1:0]    resp_val;
    logic [N-1:0]    resp_rdy;
    logic [MW-1:0]   resp_msg;
    logic            cfg_send_val;
    logic            cfg_send_rdy;
    logic [MW-1:0]   cfg_send_msg;
    logic            cfg_recv_val;
    logic            cfg_recv_rdy;
    logic [MW-1:0]   cfg_recv_msg;
    logic            busy;
    logic            timeout_err;

    logic [MW-1:0]   msgs [N];
    logic [MW-1:0]   exp_q [$];
    int              compared   = 0;
    int              mismatched = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req_msg[i*MW +: MW] = msgs[i];
    end

    config_arb #(
        .NUM_REQ      (N),
        .ADDR_SIZE    (AW),
        .PAYLOAD_SIZE (PW),
        .TIMEOUT      (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .cfg_send_val (cfg_send_val),
        .cfg_send_rdy (cfg_send_rdy),
        .cfg_send_msg (cfg_send_msg),
        .cfg_recv_val (cfg_recv_val),
        .cfg_recv_rdy (cfg_recv_rdy),
        .cfg_recv_msg (cfg_recv_msg),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_rdy"}, req_rdy, 0);
        chk({tag, "_resp_val"}, resp_val, 0);
        chk({tag, "_send_val"}, cfg_send_val, 0);
        chk({tag, "_recv_rdy"}, cfg_recv_rdy, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
    endtask

    // Runs one transaction from an IDLE cycle: grant, optional send stall,
    // reply after `delay` WAIT cycles (or never), optional response stall.
    task automatic txn(input int owner, input int send_stall, input int resp_stall,
                       input bit respond, input int delay, input logic [MW-1:0] reply);
        logic [MW-1:0] m;
        logic [N-1:0]  oh;
        logic [MW-1:0] exp_resp;
        logic [MW-1:0] got;
        m        = msgs[owner];
        oh       = N'(1) << owner;
        exp_resp = respond ? reply : {m[MW-1 -: AW], {(PW+1){1'b0}}};
        #1;
        chk("grant", req_rdy, oh);
        chk("idle_busy", busy, 0);
        exp_q.push_back(exp_resp);
        cyc();
        for (int s = 0; s <= send_stall; s++) begin
            cfg_send_rdy = (s == send_stall);
            cfg_recv_val = (s < send_stall);
            cfg_recv_msg = '1;
            #1;
            chk("send_val", cfg_send_val, 1);
            chk("send_msg", cfg_send_msg, m);
            chk("issue_no_grant", req_rdy, 0);
            chk("issue_recv_rdy", cfg_recv_rdy, 0);
            chk("issue_busy", busy, 1);
            cyc();
        end
        cfg_send_rdy = 1'b0;
        for (int w = 0; w < TO; w++) begin
            cfg_recv_val = respond && (w == delay);
            cfg_recv_msg = reply;
            #1;
            chk("recv_rdy", cfg_recv_rdy, 1);
            chk("wait_send_val", cfg_send_val, 0);
            cyc();
            if (cfg_recv_val) break;
        end
        cfg_recv_val = 1'b0;
        got = '0;
        for (int r = 0; r <= resp_stall; r++) begin
            resp_rdy = (r == resp_stall) ? oh : ~oh;
            #1;
            chk("timeout_err", timeout_err, (r == 0) ? 32'(!respond) : 0);
            chk("resp_val", resp_val, oh);
            chk("resp_no_grant", req_rdy, 0);
            if (r == 0) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else got = exp_q.pop_front();
            end
            chk("resp_msg", resp_msg, got);
            cyc();
        end
        resp_rdy = '0;
    endtask

    initial begin
        reset        = 1'b1;
        req_val      = '1;
        resp_rdy     = '0;
        cfg_send_rdy = 1'b0;
        cfg_recv_val = 1'b0;
        cfg_recv_msg = '0;
        msgs[0] = {4'h8, 1'b1, 8'h11};
        msgs[1] = {4'h0, 1'b1, 8'hA5};
        msgs[2] = {4'h3, 1'b1, 8'h5C};
        msgs[3] = {4'hB, 1'b0, 8'h7E};

        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk_quiet("in_reset");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fairness with all four requesting, starting from rr_ptr = 0.
        txn(0, 0, 0, 1, 0, msgs[0]);
        txn(1, 0, 0, 1, 0, msgs[1] ^ 13'h0FF);
        txn(2, 0, 0, 1, 0, msgs[2]);
        txn(3, 0, 0, 1, 0, msgs[3]);
        txn(0, 0, 0, 1, 0, msgs[0] ^ 13'h1000);

        req_val = 4'b0010;
        txn(1, 0, 0, 1, 0, msgs[1]);

        // Reply lands on the final WAIT cycle: no timeout expected.
        req_val = 4'b1000;
        txn(3, 0, 0, 1, TO - 1, msgs[3] ^ 13'h00F);

        req_val = 4'b0100;
        txn(2, 0, 0, 0, 0, '0);

        // rr_ptr is 3 here; only requester 0 asks, with send and response stalls.
        req_val = 4'b0001;
        txn(0, 5, 3, 1, 2, 13'h1C3);

        // Reset while waiting for the register; rr_ptr is 1 going in.
        req_val = 4'b1000;
        #1;
        chk("rst_grant", req_rdy, 4'b1000);
        cyc();
        cfg_send_rdy = 1'b1;
        #1;
        chk("rst_send_val", cfg_send_val, 1);
        cyc();
        cfg_send_rdy = 1'b0;
        #1;
        chk("rst_recv_rdy", cfg_recv_rdy, 1);
        cyc();
        reset = 1'b1;
        #1;
        chk_quiet("rst_hold");
        cyc();
        reset   = 1'b0;
        req_val = '1;
        #1;
        chk("rst_ptr_zero", req_rdy, 4'b0001);
        chk("rst_idle_busy", busy, 0);
        chk("rst_no_resp", resp_val, 0);
        chk("rst_no_recv_rdy", cfg_recv_rdy, 0);
        txn(0, 0, 0, 1, 1, msgs[0]);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/config_arb.md
CONFIG_ARB -- requirements
Module: config_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one configuration register port.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, message address field width.
REQ-003 SHALL have parameter PAYLOAD_SIZE, default 8, message payload width; MSG_W = ADDR_SIZE+PAYLOAD_SIZE+1, format {addr, flag, payload}.
REQ-004 SHALL have parameter TIMEOUT, default 16, max cycles waited for a downstream response.
REQ-005 SHALL provide: clk  input  1  single clock; reset is synchronous and active-high.
REQ-006 SHALL provide: reset  input  1  synchronous active-high reset.
REQ-007 SHALL provide: req_val  input  NUM_REQ  per-requester request valid.
REQ-008 SHALL provide: req_rdy  output  NUM_REQ  per-requester request ready (at most one bit high).
REQ-009 SHALL provide: req_msg  input  NUM_REQ*MSG_W  packed requests, requester i at bits [i*MSG_W +: MSG_W].
REQ-010 SHALL provide: resp_val  output  NUM_REQ  one-hot response valid to the owning requester.
REQ-011 SHALL provide: resp_rdy  input  NUM_REQ  per-requester response ready.
REQ-012 SHALL provide: resp_msg  output  MSG_W  response message, shared, qualified by resp_val.
REQ-013 SHALL provide: cfg_send_val / cfg_send_rdy / cfg_send_msg  output / input / output  1 / 1 / MSG_W  request channel to the configuration register.
REQ-014 SHALL provide: cfg_recv_val / cfg_recv_rdy / cfg_recv_msg  input / output / input  1 / 1 / MSG_W  response channel from the configuration register.
REQ-015 SHALL provide: busy  output  1  high in any state other than IDLE; timeout_err  output  1  one-cycle pulse on timeout.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-017 In IDLE, SHALL grant round-robin: first requester with req_val high searching from rr_ptr upward, wrapping at NUM_REQ-1 to 0; req_rdy asserted only for the winner, combinationally.
REQ-018 On grant handshake, SHALL latch msg and owner id, go to ISSUE next cycle; cfg_send_val high first cycle after acceptance.
REQ-019 In ISSUE, SHALL hold cfg_send_val=1 and cfg_send_msg stable until cfg_send_rdy; then go to WAIT and clear timer.
REQ-020 In WAIT, SHALL hold cfg_recv_rdy=1; on cfg_recv_val latch cfg_recv_msg as response, go to RESP.
REQ-021 In WAIT, timer SHALL increment each cycle; when timer equals TIMEOUT-1 without cfg_recv_val, SHALL form response {latched addr, 0, 0}, pulse timeout_err, go to RESP.
REQ-022 cfg_recv_val on the same cycle as timeout SHALL take priority; no timeout_err.
REQ-023 cfg_recv_val outside WAIT SHALL be ignored (cfg_recv_rdy=0).
REQ-024 In RESP, SHALL assert resp_val[owner] with resp_msg stable until resp_rdy[owner]; then rr_ptr = owner+1 (wrapping), go to IDLE.
REQ-025 Minimum transaction with zero-stall partners: grant T, issue T+1, response captured T+2, resp_val T+3, next grant T+4.
REQ-026 resp_rdy of non-owners SHALL be ignored; req_val changes outside IDLE SHALL not affect state.

Reset
REQ-027 On reset, SHALL enter IDLE; rr_ptr=0, timer=0, latched msg/response=0, owner=0.
REQ-028 During and one cycle after reset exit, all req_rdy, resp_val, cfg_send_val, cfg_recv_rdy, busy, timeout_err SHALL be 0 until IDLE evaluation in the first non-reset cycle.
REQ-029 Reset mid-transaction SHALL abandon it with no response issued.

Structure
REQ-030 Shared package SHALL hold the FSM state enum, MSG_W derivation, and message field index constants.
REQ-031 Round-robin priority selection SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs one-hot grant, grant id, any).

Verification
REQ-032 Single request: req 1 sends {4'h0,1,8'hA5}, register echoes it -> resp_val=4'b0010, resp_msg={4'h0,1,8'hA5}, latency per REQ-025.
REQ-033 Fairness: req_val=4'b1111 held for 4 transactions -> grant order 0,1,2,3; fifth is 0.
REQ-034 Wrap: rr_ptr=3 after owner 2, req_val=4'b0001 -> requester 0 granted.
REQ-035 Timeout: register never asserts cfg_recv_val, addr 4'h3 -> after 16 WAIT cycles timeout_err pulse, resp_msg={4'h3,0,8'h00}.
REQ-036 Backpressure: cfg_send_rdy low 5 cycles, resp_rdy low 3 cycles -> cfg_send_msg and resp_msg stable, no new grant.
REQ-037 Reset asserted in WAIT -> next cycle IDLE, no resp_val, rr_ptr=0.
